// File: rtl/instr_prefetch_master_pkg.sv
// Shared types for the instruction prefetch master:
// native-bus request bundle, request FSM states, word size.
package instr_prefetch_master_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] WORD_MASK  = WORD_BYTES - 32'd1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/instr_prefetch_master_fifo.sv
// Fetch buffer: DEPTH x {addr, data} entries, flushable.
// Head entry is read straight from the storage registers.
module prefetch_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [63:0]   i_data,
  output logic [63:0]   o_data,
  output logic [CW-1:0] o_count
);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push &&
                  ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_master.sv
// Sequential instruction prefetcher on the native mem bus,
// with redirect flush and stale-response discard.
module instr_prefetch_master
  import instr_prefetch_master_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [31:0]   r_fetch_ptr;
  logic [31:0]   w_fetch_nxt;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_addr_nxt;
  logic          r_stale;
  logic          w_stale_nxt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic          w_credit;
  logic [63:0]   w_head;
  mem_req_t      w_req;

  assign w_xfer = (r_state == REQ) && mem_ready;
  assign w_push = w_xfer && !r_stale && !redirect_valid;
  assign w_pop  = out_ready && (w_count != '0) &&
                  !redirect_valid;

  // Occupancy after this edge; a redirect empties the buffer.
  assign w_cnt_nxt = redirect_valid ? '0 :
                     (w_count + CW'(w_push) - CW'(w_pop));
  assign w_credit  = w_cnt_nxt < FULL;

  always_comb begin
    w_state_nxt = r_state;
    w_fetch_nxt = r_fetch_ptr;
    w_addr_nxt  = r_mem_addr;
    w_stale_nxt = r_stale;
    if (redirect_valid)
      w_fetch_nxt = redirect_addr & ~WORD_MASK;
    else if (w_push)
      w_fetch_nxt = r_fetch_ptr + WORD_BYTES;
    if (w_xfer)
      w_stale_nxt = 1'b0;
    else if (redirect_valid && (r_state == REQ))
      w_stale_nxt = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_credit) begin
          w_state_nxt = REQ;
          w_addr_nxt  = w_fetch_nxt;
        end
      end
      REQ: begin
        if (w_xfer) begin
          if (w_credit)
            w_addr_nxt = w_fetch_nxt;
          else
            w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_fetch_ptr <= PROGADDR_RESET & ~WORD_MASK;
      r_mem_addr  <= '0;
      r_stale     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_ptr <= w_fetch_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_stale     <= w_stale_nxt;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_mem_addr, mem_rdata}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign w_req = '{
    valid: (r_state == REQ),
    instr: (r_state == REQ),
    addr:  r_mem_addr,
    wdata: 32'h0,
    wstrb: 4'h0
  };

  assign mem_valid = w_req.valid;
  assign mem_instr = w_req.instr;
  assign mem_addr  = w_req.addr;
  assign mem_wdata = w_req.wdata;
  assign mem_wstrb = w_req.wstrb;

  assign out_valid = (w_count != '0);
  assign out_addr  = w_head[63:32];
  assign out_data  = w_head[31:0];

endmodule

// File: tb/tb_instr_prefetch_master.sv
// Bench for instr_prefetch_master: memory image word k = A0000000+k,
// randomized responder delays, stream-level reference model.
module tb_instr_prefetch_master;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PRA   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  bit          rsp_en = 1'b0;
  int          dmin = 0, dmax = 0, dly = 0, wcnt = 0;
  logic        pv, pr, xf;
  logic [31:0] pa, xf_addr;
  logic [31:0] exp_next, exp_req;

  instr_prefetch_master #(
    .DEPTH          (DEPTH),
    .PROGADDR_RESET (PRA)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_addr       (out_addr),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  task automatic set_rsp(input int lo, input int hi);
    dmin = lo;
    dmax = hi;
    dly = $urandom_range(hi, lo);
    wcnt = 0;
    rsp_en = 1'b1;
  endtask

  // One clock: records whether the last edge was a transfer,
  // then plays the responder for the next edge.
  task automatic step();
    pv = mem_valid;
    pa = mem_addr;
    pr = mem_ready;
    @(negedge clk);
    xf = pv && pr;
    xf_addr = pa;
    if (rsp_en && mem_valid) begin
      if (wcnt >= dly) begin
        mem_ready = 1'b1;
        mem_rdata = img(mem_addr);
        wcnt = 0;
        dly = $urandom_range(dmax, dmin);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    redirect_valid = 1'b0;
    wcnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rsp_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total += 8;
    if (mem_valid !== 1'b0) begin bad++;
      $display("FAIL rst_mem_valid got=%b want=0", mem_valid); end
    if (mem_addr !== 32'h0) begin bad++;
      $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    if (mem_instr !== 1'b0) begin bad++;
      $display("FAIL rst_mem_instr got=%b want=0", mem_instr); end
    if (out_valid !== 1'b0) begin bad++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    if (out_data !== 32'h0) begin bad++;
      $display("FAIL rst_out_data got=%h want=0", out_data); end
    if (out_addr !== 32'h0) begin bad++;
      $display("FAIL rst_out_addr got=%h want=0", out_addr); end
    if (mem_wstrb !== 4'h0) begin bad++;
      $display("FAIL rst_wstrb got=%h want=0", mem_wstrb); end
    if (mem_wdata !== 32'h0) begin bad++;
      $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    reset = 1'b0;
    step();
    total += 2;
    if (mem_valid !== 1'b1) begin bad++;
      $display("FAIL first_req_valid got=%b want=1", mem_valid); end
    if (mem_addr !== PRA) begin bad++;
      $display("FAIL first_req_addr got=%h want=%h", mem_addr, PRA); end
    step();
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== PRA) begin bad++;
      $display("FAIL req_hold got=%b/%h want=1/%h",
               mem_valid, mem_addr, PRA); end
  endtask

  task automatic test_stream();
    int n;
    n = 0;
    set_rsp(0, 0);
    out_ready = 1'b1;
    exp_next = PRA;
    exp_req = PRA;
    for (int i = 0; i < 60; i++) begin
      if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL stream_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
      if (xf) begin
        total++;
        if (xf_addr !== exp_req) begin bad++;
          $display("FAIL stream_req got=%h want=%h", xf_addr, exp_req); end
        exp_req += 32'd4;
      end
    end
    total++;
    if (n < 40) begin bad++;
      $display("FAIL stream_count got=%0d want>=40", n); end
  endtask

  task automatic test_backpressure();
    int nx, n;
    nx = 0;
    n = 0;
    do_reset();
    out_ready = 1'b0;
    set_rsp(0, 0);
    exp_req = PRA;
    exp_next = PRA;
    for (int i = 0; i < 30; i++) begin
      step();
      if (xf) begin
        total++;
        if (xf_addr !== exp_req) begin bad++;
          $display("FAIL bp_req got=%h want=%h", xf_addr, exp_req); end
        exp_req += 32'd4;
        nx++;
      end
    end
    total += 4;
    if (nx != DEPTH) begin bad++;
      $display("FAIL bp_nreq got=%0d want=%0d", nx, DEPTH); end
    if (mem_valid !== 1'b0) begin bad++;
      $display("FAIL bp_idle got=%b want=0", mem_valid); end
    if (out_valid !== 1'b1) begin bad++;
      $display("FAIL bp_outv got=%b want=1", out_valid); end
    if (out_addr !== PRA || out_data !== img(PRA)) begin bad++;
      $display("FAIL bp_head got=%h:%h want=%h:%h",
               out_addr, out_data, PRA, img(PRA)); end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL bp_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
      if (xf) begin
        total++;
        if (xf_addr !== exp_req) begin bad++;
          $display("FAIL bp_resume got=%h want=%h", xf_addr, exp_req); end
        exp_req += 32'd4;
      end
    end
    total++;
    if (n < 30) begin bad++;
      $display("FAIL bp_count got=%0d want>=30", n); end
  endtask

  task automatic test_redirect_outstanding();
    bit found;
    int k, n;
    logic [31:0] want;
    found = 1'b0;
    k = 0;
    n = 0;
    do_reset();
    out_ready = 1'b0;
    set_rsp(3, 3);
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (mem_valid && mem_addr == 32'h8 && !mem_ready)
        found = 1'b1;
    end
    total++;
    if (!found) begin bad++;
      $display("FAIL ro_timeout got=0 want=1"); end
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0102;
        out_ready = 1'b1;
        exp_next = 32'h100;
      end else if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL ro_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
      if (i == 0) begin
        redirect_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++;
          $display("FAIL ro_flush got=%b want=0", out_valid); end
      end
      if (xf) begin
        if (k < 2) begin
          want = (k == 0) ? 32'h8 : 32'h100;
          total++;
          if (xf_addr !== want) begin bad++;
            $display("FAIL ro_req%0d got=%h want=%h", k, xf_addr, want); end
        end
        k++;
      end
    end
    total += 2;
    if (k < 2) begin bad++;
      $display("FAIL ro_nreq got=%0d want>=2", k); end
    if (n < 3) begin bad++;
      $display("FAIL ro_count got=%0d want>=3", n); end
  endtask

  task automatic test_redirect_on_xfer();
    bit found;
    int n;
    found = 1'b0;
    n = 0;
    do_reset();
    out_ready = 1'b0;
    set_rsp(0, 0);
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mem_valid && mem_ready && mem_addr == 32'hC)
        found = 1'b1;
    end
    total += 2;
    if (!found) begin bad++;
      $display("FAIL rx_timeout got=0 want=1"); end
    if (out_valid !== 1'b1 || out_addr !== 32'h0) begin bad++;
      $display("FAIL rx_pre got=%b:%h want=1:0", out_valid, out_addr); end
    redirect_valid = 1'b1;
    redirect_addr = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    total += 3;
    if (!(xf && xf_addr == 32'hC)) begin bad++;
      $display("FAIL rx_xfer got=%b:%h want=1:c", xf, xf_addr); end
    if (out_valid !== 1'b0) begin bad++;
      $display("FAIL rx_flush got=%b want=0", out_valid); end
    if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin bad++;
      $display("FAIL rx_next got=%b:%h want=1:200", mem_valid, mem_addr); end
    out_ready = 1'b1;
    exp_next = 32'h200;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL rx_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
    end
    total++;
    if (n < 5) begin bad++;
      $display("FAIL rx_count got=%0d want>=5", n); end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] tgt;
    n = 0;
    do_reset();
    set_rsp(0, 5);
    exp_next = PRA;
    for (int i = 0; i < 700; i++) begin
      out_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(39, 0) == 0) begin
        tgt = (i < 350) ? $urandom : 32'hFFFF_FFF6;
        redirect_valid = 1'b1;
        redirect_addr = tgt;
        exp_next = tgt & ~32'h3;
      end else if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL rnd_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
      redirect_valid = 1'b0;
      if (mem_valid) begin
        total++;
        if (mem_instr !== 1'b1 || mem_wstrb !== 4'h0 ||
            mem_wdata !== 32'h0 || mem_addr[1:0] !== 2'b00) begin
          bad++;
          $display("FAIL rnd_req got=%b/%h/%h/%h want=1/0/0/aligned",
                   mem_instr, mem_wstrb, mem_wdata, mem_addr);
        end
      end
      if (pv && !pr) begin
        total++;
        if (mem_valid !== 1'b1 || mem_addr !== pa) begin bad++;
          $display("FAIL rnd_hold got=%b:%h want=1:%h",
                   mem_valid, mem_addr, pa); end
      end
    end
    total++;
    if (n < 60) begin bad++;
      $display("FAIL rnd_count got=%0d want>=60", n); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n;
    found = 1'b0;
    n = 0;
    out_ready = 1'b0;
    set_rsp(5, 5);
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mem_valid && !mem_ready)
        found = 1'b1;
    end
    total++;
    if (!found) begin bad++;
      $display("FAIL rm_timeout got=0 want=1"); end
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    total += 2;
    if (mem_valid !== 1'b0) begin bad++;
      $display("FAIL rm_valid got=%b want=0", mem_valid); end
    if (out_valid !== 1'b0) begin bad++;
      $display("FAIL rm_outv got=%b want=0", out_valid); end
    @(negedge clk);
    reset = 1'b0;
    set_rsp(0, 0);
    out_ready = 1'b1;
    exp_next = PRA;
    exp_req = PRA;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) begin
        total++;
        if (out_addr !== exp_next || out_data !== img(exp_next)) begin
          bad++;
          $display("FAIL rm_out got=%h:%h want=%h:%h",
                   out_addr, out_data, exp_next, img(exp_next));
        end
        exp_next += 32'd4;
        n++;
      end
      step();
      if (xf) begin
        total++;
        if (xf_addr !== exp_req) begin bad++;
          $display("FAIL rm_req got=%h want=%h", xf_addr, exp_req); end
        exp_req += 32'd4;
      end
    end
    total++;
    if (n < 10) begin bad++;
      $display("FAIL rm_count got=%0d want>=10", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_on_xfer();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_master.md
# instr_prefetch_master

Synthesizable initiator for the picorv32-style native memory interface (mem_valid/mem_ready). It issues sequential word-aligned instruction fetches, buffers the returned words in a small FIFO, and hands them to a downstream consumer such as the compressed-instruction decompressor. It supports redirects (branch/jump) that flush buffered and in-flight data. It sits between the fetch consumer and the shared memory responder, in place of the core's own fetch path.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- PROGADDR_RESET, 32'h0000_0000: first fetch address after reset
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_addr
- redirect_addr  in  32  new fetch address; bits [1:0] ignored
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  32  fetched word at head
- out_addr  out  32  word address of out_data
- mem_valid  out  1  request valid
- mem_instr  out  1  constant 1 while mem_valid
- mem_ready  in  1  responder completes request this cycle
- mem_addr  out  32  request address, word-aligned
- mem_wdata  out  32  constant 0
- mem_wstrb  out  4  constant 4'b0000 (read only)
- mem_rdata  in  32  read data, sampled when mem_valid && mem_ready

## Operation
- Reset values: mem_valid=0, mem_addr=0, mem_instr=0, out_valid=0, out_data=0, out_addr=0; fetch pointer = PROGADDR_RESET & ~3; FIFO empty; stale=0.
- Transfer = mem_valid && mem_ready at a rising edge. At most one request outstanding.
- Once mem_valid rises, mem_valid and mem_addr stay stable until the transfer. A request is never withdrawn, including on redirect.
- Credit: issue a request only if (FIFO count + outstanding) < DEPTH.
- States:
  - IDLE: mem_valid=0. Go to REQ when credit is available.
  - REQ: mem_valid=1. On transfer:
    - if not stale: push {fetch_addr, mem_rdata} and advance fetch pointer by 4 (wraps modulo 2^32);
    - if stale: drop the data and clear stale.
    - Then stay in REQ with the next address if credit remains after the push, else go to IDLE.
- Redirect:
  - Flush the FIFO (count=0, out_valid=0 next cycle) and set fetch pointer = redirect_addr & ~3.
  - If a request is outstanding and not transferring this cycle, set stale; the request completes normally and its data is discarded.
  - Redirect on the same edge as a transfer: that data is discarded, and the next request uses the redirect address.
  - Redirect with out_ready on the same edge: redirect wins and the pop is irrelevant.
  - Back-to-back redirects: the last one wins; stale covers a single outstanding request.
- FIFO:
  - Push and pop on the same edge with the FIFO full is legal; count is unchanged.
  - Pop when empty is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

## Timing
- Fetch request latency:
  - First mem_valid rises 1 cycle after reset deassertion.
  - After a redirect at edge N with nothing outstanding, mem_valid rises with the new address after edge N.
- Transfer to out_valid: 1 cycle. Data captured at the transfer edge appears on out_data after that edge.
- Back-to-back: mem_valid may stay high across a transfer with mem_addr advanced by 4 on the same edge. Throughput is limited only by the responder.
- All outputs are registered. No combinational path from out_ready or mem_ready to any output.
- Reset asserted mid-transfer forces mem_valid=0 immediately (asynchronous). The responder must tolerate this.

## Structure
- Shared package: native-bus request struct (valid, instr, addr, wdata, wstrb), state enum {IDLE, REQ}, constant WORD_BYTES=4.
- One sub-module: prefetch_fifo (DEPTH x 64-bit entries, push/pop/count, asynchronous active-high reset).
- Top level holds the request FSM, fetch pointer, stale flag and credit logic.

## Test plan
- Reset release, memory with word k = 32'hA000_0000+k, responder ready 1 cycle after valid, out_ready=1 → mem_addr sequence 0,4,8…, out_data A0000000, A0000001… in order with matching out_addr.
- out_ready=0 throughout → exactly DEPTH=4 requests (addr 0..C), FIFO full, mem_valid=0. Set out_ready=1 → fetching resumes at 0x10 and no word is lost or duplicated.
- Redirect to 0x0000_0102 while the request to 0x8 is outstanding → 0x8 completes but is discarded. Next mem_addr = 0x100. First out_addr after redirect = 0x100.
- Redirect on the same edge as a transfer, with the FIFO holding 3 words → FIFO empties, the transferred word never appears, next request is at the redirect address.
- Responder with random 0–5 cycle ready delay → mem_valid/mem_addr stable until ready, mem_wstrb=0 and mem_instr=1 on every request, output stream matches the memory image.
- Assert reset for 1 cycle while mem_valid=1 → mem_valid, out_valid=0 immediately. Fetching restarts at PROGADDR_RESET.
